// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding and fetch FSM states.
package cpu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

    // IDLE: no request outstanding
    // WAIT: right-path request outstanding
    // DROP: wrong-path request outstanding, its data will be thrown away
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer for fetched {pc, instruction} pairs.
// Head entry is presented combinationally; flush empties it on the next edge.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack memory request, small
// prefetch buffer, stall and redirect handling, NOP when nothing is ready.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] PC_if,
    output logic [XLEN-1:0] inst_if
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state, state_n;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_n, addr_n;
    logic              push, pop, flush, room;
    logic [CW-1:0]     count, count_next;
    logic [2*XLEN-1:0] head;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({fetch_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    // Redirect suppresses both push and pop; the flush takes over.
    assign pop        = if_valid && !stall && !redirect;
    assign push       = (state == WAIT) && imem_ack && !redirect;
    assign count_next = count + CW'(push) - CW'(pop);
    assign room       = count_next < CW'(DEPTH);

    // Presented instruction: FIFO head or NOP bubble.
    assign if_valid = (count != '0);
    assign PC_if    = if_valid ? head[2*XLEN-1:XLEN] : '0;
    assign inst_if  = if_valid ? head[XLEN-1:0]      : NOP_INST;

    // State and fetch datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            imem_addr <= addr_n;
        end
    end

    // Next-state logic; imem_addr only moves when a new request starts.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = imem_addr;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                end else if (room) begin
                    state_n = WAIT;
                    addr_n  = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                    state_n    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetch_pc_n = fetch_pc + 32'd1;
                    if (room) addr_n  = fetch_pc + 32'd1;
                    else      state_n = IDLE;
                end
            end
            DROP: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                end
                if (imem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request is held for the whole time a request is outstanding.
    always_comb begin
        imem_req = (state == WAIT) || (state == DROP);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a reset sequence.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] PC_if;
    logic [31:0] inst_if;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .PC_if       (PC_if),
        .inst_if     (inst_if)
    );

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Row: inputs driven for the next edge, outputs expected before that edge.
    typedef struct {
        logic        stall;
        logic        redirect;
        logic        ack;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [64];
    int   nv = 0;

    task automatic add(input logic st, input logic rd, input logic ak, input logic [31:0] rpc,
                       input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc);
        vecs[nv].stall    = st;
        vecs[nv].redirect = rd;
        vecs[nv].ack      = ak;
        vecs[nv].rpc      = rpc;
        vecs[nv].req      = req;
        vecs[nv].addr     = addr;
        vecs[nv].v        = v;
        vecs[nv].pc       = pc;
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic v, input logic [31:0] pc);
        chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".vld"},  {31'd0, if_valid}, {31'd0, v});
        chk({tag, ".pc"},   PC_if, v ? pc : 32'h0);
        chk({tag, ".inst"}, inst_if, v ? mem_word(pc) : 32'h0);
    endtask

    initial begin
        //   st rd ak rpc            req addr          v  pc
        // free-running fetch with memory acking every cycle
        add(0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h0,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h1,        1, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h2,        1, 32'h1);
        // stall: buffer fills, request drops, head frozen
        add(1, 0, 1, 32'h0,        1, 32'h3,        1, 32'h2);
        add(1, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        add(1, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        add(1, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        add(1, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        add(1, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        // release: pop frees space, fetch resumes without gaps
        add(0, 0, 1, 32'h0,        0, 32'h3,        1, 32'h2);
        add(0, 0, 1, 32'h0,        1, 32'h4,        1, 32'h3);
        add(0, 0, 0, 32'h0,        1, 32'h5,        1, 32'h4);
        // empty buffer: NOP, stall has no effect
        add(1, 0, 0, 32'h0,        1, 32'h5,        0, 32'h0);
        add(1, 0, 1, 32'h0,        1, 32'h5,        0, 32'h0);
        // redirect while waiting, ack arrives 3 cycles later and is dropped
        add(0, 1, 0, 32'h40,       1, 32'h6,        1, 32'h5);
        add(0, 0, 0, 32'h0,        1, 32'h6,        0, 32'h0);
        add(0, 0, 0, 32'h0,        1, 32'h6,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h6,        0, 32'h0);
        add(0, 0, 1, 32'h0,        0, 32'h6,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h40,       0, 32'h0);
        // redirect together with ack
        add(0, 1, 1, 32'h80,       1, 32'h41,       1, 32'h40);
        add(0, 0, 0, 32'h0,        0, 32'h41,       0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h80,       0, 32'h0);
        // redirect to the top of the address space, PC wraps
        add(0, 1, 0, 32'hFFFF_FFFF, 1, 32'h81,      1, 32'h80);
        add(0, 0, 1, 32'h0,        1, 32'h81,       0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h81,       0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'hFFFF_FFFF, 0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFF);
        // two redirects while in DROP: the latest target wins
        add(0, 1, 0, 32'h100,      1, 32'h1,        1, 32'h0);
        add(0, 1, 0, 32'h200,      1, 32'h1,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h1,        0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 32'h1,        0, 32'h0);
        add(0, 0, 1, 32'h0,        1, 32'h200,      0, 32'h0);
        add(1, 0, 0, 32'h0,        1, 32'h201,      1, 32'h200);

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < nv; i++) begin
            chk_all($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].pc);
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            imem_ack    = vecs[i].ack;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
        end

        // Mid-WAIT asynchronous reset with a valid head entry.
        chk_all("prerst", 1'b1, 32'h201, 1'b1, 32'h200);
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("asyncrst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        #1 chk_all("postrst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_all("stray_ack", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_all("restart", 1'b1, 32'h1, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
